// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg_chain
//  Description : Parametrised chain of pipeline stage registers carrying a
//                payload plus valid bit. Supports freeze (hold + bubble),
//                partial flush, occupancy tracking and a retired counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_chain #(
    parameter int DATA_W     = 32,
    parameter int STAGES     = 4,
    parameter int HOLD_UPTO  = 0,
    parameter int FLUSH_UPTO = 0,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    input  logic                          freeze,
    input  logic                          flush,
    output logic [STAGES-1:0]             stage_valid,
    output logic [STAGES*DATA_W-1:0]      stage_data,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(STAGES+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]              retired_cnt
);

    localparam int c_OCC_W = $clog2(STAGES + 1);

    // Elaboration-time guards on the parameter ranges
    if (STAGES < 2) begin : g_bad_stages
        $error("pipe_reg_chain: STAGES must be at least 2");
    end
    if (HOLD_UPTO < 0 || HOLD_UPTO >= STAGES - 1) begin : g_bad_hold
        $error("pipe_reg_chain: HOLD_UPTO must be in 0..STAGES-2");
    end
    if (FLUSH_UPTO < 0 || FLUSH_UPTO >= STAGES) begin : g_bad_flush
        $error("pipe_reg_chain: FLUSH_UPTO must be in 0..STAGES-1");
    end

    logic [STAGES-1:0]        r_valid;
    logic [STAGES*DATA_W-1:0] r_data;
    logic [c_OCC_W-1:0]       r_occ;
    logic [CNT_W-1:0]         r_retired;

    logic [STAGES-1:0]        w_valid_next;
    logic [STAGES*DATA_W-1:0] w_data_next;
    logic [c_OCC_W-1:0]       w_occ_next;

    // Any freeze or flush stalls the front of the chain, so the input is refused
    assign in_ready = !freeze && !flush;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Static role of this stage relative to the hold and flush boundaries
        localparam bit c_KILL      = (k <= FLUSH_UPTO);
        localparam bit c_HOLD      = (k <= HOLD_UPTO);
        localparam bit c_HOLD_BUB  = (k == HOLD_UPTO + 1);
        localparam bit c_FLUSH_BUB = (k == FLUSH_UPTO + 1);

        logic              w_prev_valid;
        logic [DATA_W-1:0] w_prev_data;
        logic              w_nxt_valid;
        logic [DATA_W-1:0] w_nxt_data;

        // Stage 0 is fed from the input (payload zeroed when invalid), others from their predecessor
        if (k == 0) begin : g_head
            assign w_prev_valid = in_valid;
            assign w_prev_data  = in_valid ? in_data : '0;
        end else begin : g_body
            assign w_prev_valid = r_valid[k-1];
            assign w_prev_data  = r_data[(k-1)*DATA_W +: DATA_W];
        end

        // Next-state selection: flush kill beats freeze hold; a stage whose source is held or killed takes a bubble
        always_comb begin
            w_nxt_valid = w_prev_valid;
            w_nxt_data  = w_prev_data;
            if (flush && c_KILL) begin
                w_nxt_valid = 1'b0;
                w_nxt_data  = '0;
            end else if (freeze && c_HOLD) begin
                w_nxt_valid = r_valid[k];
                w_nxt_data  = r_data[k*DATA_W +: DATA_W];
            end else if ((freeze && c_HOLD_BUB) || (flush && c_FLUSH_BUB)) begin
                w_nxt_valid = 1'b0;
                w_nxt_data  = '0;
            end
        end

        assign w_valid_next[k]                    = w_nxt_valid;
        assign w_data_next[k*DATA_W +: DATA_W]    = w_nxt_data;
    end

    // Popcount of the next valid vector so the registered occupancy tracks stage_valid exactly
    always_comb begin
        w_occ_next = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_occ_next = w_occ_next + c_OCC_W'(w_valid_next[i]);
        end
    end

    // Stage registers, occupancy and retired counter with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= '0;
            r_data    <= '0;
            r_occ     <= '0;
            r_retired <= '0;
        end else begin
            r_valid <= w_valid_next;
            r_data  <= w_data_next;
            r_occ   <= w_occ_next;
            if (r_valid[STAGES-1]) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign stage_valid = r_valid;
    assign stage_data  = r_data;
    assign out_valid   = r_valid[STAGES-1];
    assign out_data    = r_data[(STAGES-1)*DATA_W +: DATA_W];
    assign occupancy   = r_occ;
    assign retired_cnt = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_reg_chain
//  Description : Self-checking bench for pipe_reg_chain. Two instances with
//                different hold/flush boundaries share one stimulus stream;
//                a behavioural model is compared every cycle, and directed
//                literal expectations pin key scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg_chain;

    localparam int NS = 4;

    logic clk;
    logic rst;
    logic in_valid;
    logic [31:0] in_data;
    logic freeze;
    logic flush;

    // Instance A: HOLD_UPTO=0, FLUSH_UPTO=1, 4-bit retired counter
    logic         rdy_a, ov_a;
    logic [3:0]   sv_a;
    logic [127:0] sd_a;
    logic [31:0]  od_a;
    logic [2:0]   occ_a;
    logic [3:0]   ret_a;
    // Instance B: HOLD_UPTO=1, FLUSH_UPTO=0, 16-bit retired counter
    logic         rdy_b, ov_b;
    logic [3:0]   sv_b;
    logic [127:0] sd_b;
    logic [31:0]  od_b;
    logic [2:0]   occ_b;
    logic [15:0]  ret_b;

    pipe_reg_chain #(.DATA_W(32), .STAGES(NS), .HOLD_UPTO(0), .FLUSH_UPTO(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a),
        .freeze(freeze), .flush(flush), .stage_valid(sv_a), .stage_data(sd_a),
        .out_valid(ov_a), .out_data(od_a), .occupancy(occ_a), .retired_cnt(ret_a)
    );

    pipe_reg_chain #(.DATA_W(32), .STAGES(NS), .HOLD_UPTO(1), .FLUSH_UPTO(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_b),
        .freeze(freeze), .flush(flush), .stage_valid(sv_b), .stage_data(sd_b),
        .out_valid(ov_b), .out_data(od_b), .occupancy(occ_b), .retired_cnt(ret_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          mv   [2][NS];
    bit [31:0]   md   [2][NS];
    int unsigned mret [2];
    int hold_up  [2] = '{0, 1};
    int flush_up [2] = '{1, 0};
    int cntw     [2] = '{4, 16};

    task automatic model_clear(input int n);
        for (int k = 0; k < NS; k++) begin
            mv[n][k] = 1'b0;
            md[n][k] = '0;
        end
        mret[n] = 0;
    endtask

    // Each stage either dies (flush), stays put (freeze), or receives what its
    // predecessor hands over; a predecessor that is held or killed hands over nothing.
    task automatic model_step(input int n);
        bit        ov [NS];
        bit [31:0] od [NS];
        bit        killed [NS];
        bit        held [NS];
        for (int k = 0; k < NS; k++) begin
            ov[k]     = mv[n][k];
            od[k]     = md[n][k];
            killed[k] = flush && (k <= flush_up[n]);
            held[k]   = freeze && (k <= hold_up[n]) && !killed[k];
        end
        if (ov[NS-1]) mret[n] = (mret[n] + 1) % (32'd1 << cntw[n]);
        for (int k = 0; k < NS; k++) begin
            if (killed[k]) begin
                mv[n][k] = 1'b0; md[n][k] = '0;
            end else if (held[k]) begin
                mv[n][k] = ov[k]; md[n][k] = od[k];
            end else if (k == 0) begin
                mv[n][k] = in_valid; md[n][k] = in_valid ? in_data : 32'd0;
            end else if (held[k-1] || killed[k-1]) begin
                mv[n][k] = 1'b0; md[n][k] = '0;
            end else begin
                mv[n][k] = ov[k-1]; md[n][k] = od[k-1];
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_clear(0);
            model_clear(1);
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic compare_inst(input int n, input logic [3:0] sv, input logic [127:0] sd,
                                input logic ov, input logic [31:0] od, input logic [2:0] occ,
                                input logic [15:0] ret, input logic rdy);
        logic [3:0]   ev;
        logic [127:0] ed;
        int           pc;
        ev = '0; ed = '0; pc = 0;
        for (int k = 0; k < NS; k++) begin
            ev[k]          = mv[n][k];
            ed[k*32 +: 32] = md[n][k];
            pc += int'(mv[n][k]);
        end
        check($sformatf("inst%0d stage_valid", n), sv, ev);
        check($sformatf("inst%0d stage_data", n), sd, ed);
        check($sformatf("inst%0d out_valid", n), ov, ev[NS-1]);
        check($sformatf("inst%0d out_data", n), od, ed[96 +: 32]);
        check($sformatf("inst%0d occupancy", n), occ, pc);
        check($sformatf("inst%0d retired_cnt", n), ret, mret[n]);
        check($sformatf("inst%0d in_ready", n), rdy, !(freeze || flush));
    endtask

    always @(negedge clk) begin
        compare_inst(0, sv_a, sd_a, ov_a, od_a, occ_a, {12'd0, ret_a}, rdy_a);
        compare_inst(1, sv_b, sd_b, ov_b, od_b, occ_b, ret_b, rdy_b);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic fz, input logic fl);
        in_valid = v; in_data = d; freeze = fz; flush = fl;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        check("reset stage_valid", sv_a, 4'b0000);
        check("reset occupancy", occ_a, 3'd0);
        check("reset retired", ret_b, 16'd0);
        check("reset stage_data", sd_b, 128'd0);
        rst = 1'b1;

        // Streaming 0,4,8,...: first output after the 4th edge
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            tick();
            if (i == 3) begin
                check("stream first out_valid", ov_a, 1'b1);
                check("stream first out_data", od_a, 32'h0);
                check("stream occupancy full", occ_a, 3'd4);
            end
            if (i == 4) check("stream second out_data", od_a, 32'h4);
        end
        // Retires happen on edges 5..14, i.e. ten entries have left
        check("stream retired A", ret_a, 4'd10);
        check("stream retired B", ret_b, 16'd10);
        check("stream out_data edge14", od_b, 32'h28);

        // Asynchronous reset between edges with a full chain
        #2;
        rst = 1'b0;
        #1;
        check("async rst valid A", sv_a, 4'b0000);
        check("async rst data A", sd_a, 128'd0);
        check("async rst occupancy A", occ_a, 3'd0);
        check("async rst retired A", ret_a, 4'd0);
        check("async rst valid B", sv_b, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        check("post rst not yet out", ov_a, 1'b0);
        tick();
        check("post rst out_valid", ov_a, 1'b1);
        check("post rst out_data", od_a, 32'h100);

        // Freeze for two cycles while stage 0 holds 0x10
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h14, 1'b1, 1'b0);
        #1;
        check("freeze in_ready", rdy_a, 1'b0);
        tick();
        check("freeze1 stage0 data", sd_a[31:0], 32'h10);
        check("freeze1 stage1 bubble", sv_a[1], 1'b0);
        check("freeze1 out_data", od_a, 32'h08);
        tick();
        check("freeze2 stage0 data", sd_a[31:0], 32'h10);
        check("freeze2 stage1 bubble", sv_a[1], 1'b0);
        check("freeze2 out_data", od_a, 32'h0C);
        drive(1'b1, 32'h14, 1'b0, 1'b0);
        tick();
        check("freeze bubble1 out", ov_a, 1'b0);
        drive(1'b1, 32'h18, 1'b0, 1'b0);
        tick();
        check("freeze bubble2 out", ov_a, 1'b0);
        drive(1'b1, 32'h1C, 1'b0, 1'b0);
        tick();
        check("freeze held entry out", od_a, 32'h10);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        check("freeze next entry out", od_a, 32'h14);

        // Flush a full chain 0x0C,0x08,0x04,0x00
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h10, 1'b0, 1'b1);
        #1;
        check("flush in_ready", rdy_b, 1'b0);
        tick();
        check("flush valid A", sv_a, 4'b1000);
        check("flush stage3 data A", sd_a[96 +: 32], 32'h04);
        check("flush low data A", sd_a[95:0], 96'd0);
        check("flush occupancy A", occ_a, 3'd1);
        check("flush valid B", sv_b, 4'b1100);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        tick();

        // Freeze and flush together
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h10, 1'b1, 1'b1);
        tick();
        check("frz+fl valid B", sv_b, 4'b1010);
        check("frz+fl stage1 held B", sd_b[32 +: 32], 32'h08);
        check("frz+fl stage3 B", sd_b[96 +: 32], 32'h04);
        check("frz+fl stage0 B", sd_b[31:0], 32'h0);
        check("frz+fl valid A", sv_a, 4'b1000);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        tick();

        // Retired counter wrap with a 4-bit counter: 17 entries retire on edges 5..21
        do_reset();
        for (int i = 0; i < 23; i++) begin
            drive(i < 17, (i < 17) ? 32'(i + 1) : 32'd0, 1'b0, 1'b0);
            tick();
            if (i + 1 == 19) check("wrap retired F", ret_a, 4'hF);
            if (i + 1 == 20) check("wrap retired 0", ret_a, 4'h0);
            if (i + 1 == 21) begin
                check("wrap retired 1", ret_a, 4'h1);
                check("wrap retired B 17", ret_b, 16'd17);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
